// File: rtl/ysyx_23060072_if_stage_pkg.sv
// Shared fetch-stage definitions: fetch FSM encoding, bubble/reset constants,
// the fetched-word record and PC helper functions.
package ysyx_23060072_if_stage_pkg;

  localparam logic [31:0] IF_RESET_PC_DEF  = 32'h8000_0000;
  localparam logic [31:0] IF_NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] IF_PC_STEP       = 32'h0000_0004;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_WAIT = 2'd2,
    FS_BUF  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Sequential next PC; wraps modulo 2^32.
  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + IF_PC_STEP;
  endfunction

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] pc_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_23060072_fetch_buf.sv
// One-entry skid buffer: parks a fetched word and its PC while decode stalls.
module ysyx_23060072_fetch_buf
  import ysyx_23060072_if_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output logic         valid,
  output fetch_entry_t entry
);

  logic         valid_r;
  fetch_entry_t entry_r;

  // Occupancy: pop or flush empties the entry, push fills it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
    end else if (flush || pop) begin
      valid_r <= 1'b0;
    end else if (push) begin
      valid_r <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Payload capture on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_r <= {32'h0000_0000, 32'h0000_0000};
    end else if (push) begin
      entry_r <= push_entry;
    end else begin
      entry_r <= entry_r;
    end
  end

  assign valid = valid_r;
  assign entry = entry_r;

endmodule

// File: rtl/ysyx_23060072_if_stage.sv
// Instruction fetch stage with single-outstanding memory FSM, skid buffer and IF/ID register.
// Optional synchronised timer interrupt path enabled by YSYX_23060072_TIMER_IRQ_EN.
module ysyx_23060072_if_stage
  import ysyx_23060072_if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = IF_RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_hold_flag_i,
  input  logic        clean_flag_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        timer_interrupt_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] pc_o,
  output logic        timer_interrupt_o,
  output logic        fetch_busy_o
);

  fetch_state_e state_r;
  fetch_state_e state_nxt_s;
  logic [31:0]  fetch_pc_r;
  logic [31:0]  fetch_pc_nxt_s;
  logic         discard_r;
  logic         discard_nxt_s;
  logic [31:0]  instr_r;
  logic [31:0]  instr_nxt_s;
  logic [31:0]  pc_r;
  logic [31:0]  pc_nxt_s;

  logic         rsp_s;
  logic         rsp_keep_s;
  logic         buf_push_s;
  logic         buf_pop_s;
  logic         buf_flush_s;
  logic         buf_valid_s;
  logic         word_take_s;
  fetch_entry_t buf_entry_s;
  fetch_entry_t word_s;

  // A response is usable only if it is not stale and no redirect kills it.
  assign rsp_s       = (state_r == FS_WAIT) && imem_rvalid_i;
  assign rsp_keep_s  = rsp_s && !discard_r && !jump_flag_i;
  assign buf_push_s  = rsp_keep_s && if_hold_flag_i;
  assign buf_pop_s   = (state_r == FS_BUF) && buf_valid_s && !if_hold_flag_i && !jump_flag_i;
  assign buf_flush_s = (state_r == FS_BUF) && jump_flag_i;
  assign word_take_s = (rsp_keep_s && !if_hold_flag_i) || buf_pop_s;

  ysyx_23060072_fetch_buf u_fetch_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (buf_push_s),
    .pop        (buf_pop_s),
    .flush      (buf_flush_s),
    .push_entry ({imem_rdata_i, fetch_pc_r}),
    .valid      (buf_valid_s),
    .entry      (buf_entry_s)
  );

  // Source of the word handed to decode: skid buffer when draining, else memory.
  always_comb begin
    word_s = {imem_rdata_i, fetch_pc_r};
    if (state_r == FS_BUF) begin
      word_s = buf_entry_s;
    end else begin
      word_s = {imem_rdata_i, fetch_pc_r};
    end
  end

  // Fetch FSM next-state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FS_IDLE: state_nxt_s = FS_REQ;
      FS_REQ: begin
        if (imem_ready_i) begin
          state_nxt_s = FS_WAIT;
        end else begin
          state_nxt_s = FS_REQ;
        end
      end
      FS_WAIT: begin
        if (!imem_rvalid_i) begin
          state_nxt_s = FS_WAIT;
        end else if (discard_r || jump_flag_i) begin
          state_nxt_s = FS_REQ;
        end else if (if_hold_flag_i) begin
          state_nxt_s = FS_BUF;
        end else begin
          state_nxt_s = FS_REQ;
        end
      end
      FS_BUF: begin
        if (jump_flag_i || !if_hold_flag_i) begin
          state_nxt_s = FS_REQ;
        end else begin
          state_nxt_s = FS_BUF;
        end
      end
      default: state_nxt_s = FS_IDLE;
    endcase
  end

  // Discard marks the single outstanding response as stale after a redirect.
  always_comb begin
    discard_nxt_s = discard_r;
    if (jump_flag_i) begin
      case (state_r)
        FS_REQ:  discard_nxt_s = imem_ready_i;
        FS_WAIT: discard_nxt_s = !imem_rvalid_i;
        default: discard_nxt_s = 1'b0;
      endcase
    end else if (rsp_s && discard_r) begin
      discard_nxt_s = 1'b0;
    end else begin
      discard_nxt_s = discard_r;
    end
  end

  // Fetch PC: redirect target, or advance once the current word leaves the FSM.
  always_comb begin
    fetch_pc_nxt_s = fetch_pc_r;
    if (jump_flag_i) begin
      fetch_pc_nxt_s = pc_align(jump_addr_i);
    end else if (word_take_s) begin
      fetch_pc_nxt_s = pc_incr(fetch_pc_r);
    end else begin
      fetch_pc_nxt_s = fetch_pc_r;
    end
  end

  // IF/ID priority: redirect, flush, stall, new word, else bubble.
  always_comb begin
    instr_nxt_s = NOP_INSTR;
    pc_nxt_s    = pc_r;
    if (jump_flag_i) begin
      instr_nxt_s = NOP_INSTR;
      pc_nxt_s    = pc_r;
    end else if (clean_flag_i) begin
      instr_nxt_s = NOP_INSTR;
      pc_nxt_s    = pc_r;
    end else if (if_hold_flag_i) begin
      instr_nxt_s = instr_r;
      pc_nxt_s    = pc_r;
    end else if (word_take_s) begin
      instr_nxt_s = word_s.instr;
      pc_nxt_s    = word_s.pc;
    end else begin
      instr_nxt_s = NOP_INSTR;
      pc_nxt_s    = pc_r;
    end
  end

  // FSM and fetch-side state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= FS_IDLE;
      fetch_pc_r <= RESET_PC;
      discard_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      fetch_pc_r <= fetch_pc_nxt_s;
      discard_r  <= discard_nxt_s;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_r <= NOP_INSTR;
      pc_r    <= 32'h0000_0000;
    end else begin
      instr_r <= instr_nxt_s;
      pc_r    <= pc_nxt_s;
    end
  end

`ifdef YSYX_23060072_TIMER_IRQ_EN
  logic irq_meta_r;
  logic irq_sync_r;
  logic irq_r;
  logic irq_nxt_s;

  // Two-flop synchroniser for the asynchronous CLINT line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_meta_r <= 1'b0;
      irq_sync_r <= 1'b0;
    end else begin
      irq_meta_r <= timer_interrupt_i;
      irq_sync_r <= irq_meta_r;
    end
  end

  // Interrupt flag travels with the instruction it is attached to.
  always_comb begin
    irq_nxt_s = 1'b0;
    if (jump_flag_i || clean_flag_i) begin
      irq_nxt_s = 1'b0;
    end else if (if_hold_flag_i) begin
      irq_nxt_s = irq_r;
    end else if (word_take_s) begin
      irq_nxt_s = irq_sync_r;
    end else begin
      irq_nxt_s = 1'b0;
    end
  end

  // Interrupt IF/ID register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irq_nxt_s;
    end
  end

  assign timer_interrupt_o = irq_r;
`else
  logic unused_irq_s;
  assign unused_irq_s      = timer_interrupt_i;
  assign timer_interrupt_o = 1'b0;
`endif

  assign imem_req_o    = (state_r == FS_REQ);
  assign imem_addr_o   = fetch_pc_r;
  assign fetch_busy_o  = (state_r != FS_REQ);
  assign instr_rdata_o = instr_r;
  assign pc_o          = pc_r;

endmodule

// File: tb/tb_ysyx_23060072_if_stage.sv
// Directed bench for the fetch stage: vector table plus hand-written corner sequences.
module tb_ysyx_23060072_if_stage;

  localparam logic [31:0] B = 32'h8000_0000;
  localparam logic [31:0] N = 32'h0000_0013;
  localparam int MEM_LAT = 2;
`ifdef YSYX_23060072_TIMER_IRQ_EN
  localparam logic EXP_IRQ = 1'b1;
`else
  localparam logic EXP_IRQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_hold_flag_i = 1'b0;
  logic        clean_flag_i = 1'b0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = 32'h0;
  logic        timer_interrupt_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic [31:0] instr_rdata_o;
  logic [31:0] pc_o;
  logic        timer_interrupt_o;
  logic        fetch_busy_o;

  int n_chk = 0;
  int n_fail = 0;
  bit pend = 1'b0;
  int cnt = 0;
  logic [31:0] paddr = 32'h0;
  logic stray_rv = 1'b0;
  logic model_rv = 1'b0;

  typedef struct {
    logic h; logic c; logic j; logic [31:0] ja; logic r;
    logic e_req; logic e_busy; logic [31:0] e_addr; logic [31:0] e_instr; logic [31:0] e_pc;
  } vec_t;
  vec_t tbl [25];

  ysyx_23060072_if_stage dut (
    .clk(clk), .rst_n(rst_n), .if_hold_flag_i(if_hold_flag_i), .clean_flag_i(clean_flag_i),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i), .timer_interrupt_i(timer_interrupt_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ready_i(imem_ready_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .instr_rdata_o(instr_rdata_o),
    .pc_o(pc_o), .timer_interrupt_o(timer_interrupt_o), .fetch_busy_o(fetch_busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] w(input logic [31:0] a);
    if (a == 32'h8000_0004) return 32'h0000_0093;
    else return a ^ 32'h5A5A_0003;
  endfunction

  function automatic vec_t v(input logic h, input logic c, input logic j, input logic [31:0] ja,
                             input logic r, input logic er, input logic eb, input logic [31:0] ea,
                             input logic [31:0] ei, input logic [31:0] ep);
    vec_t t;
    t.h = h; t.c = c; t.j = j; t.ja = ja; t.r = r;
    t.e_req = er; t.e_busy = eb; t.e_addr = ea; t.e_instr = ei; t.e_pc = ep;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic er, input logic eb, input logic ei_irq,
                         input logic [31:0] ea, input logic [31:0] ei, input logic [31:0] ep);
    chk({nm, " ctl{req,busy,irq}"}, {29'd0, imem_req_o, fetch_busy_o, timer_interrupt_o},
        {29'd0, er, eb, ei_irq});
    chk({nm, " addr"}, imem_addr_o, ea);
    chk({nm, " instr"}, instr_rdata_o, ei);
    chk({nm, " pc"}, pc_o, ep);
  endtask

  task automatic set_in(input logic h, input logic c, input logic j, input logic [31:0] ja, input logic r);
    if_hold_flag_i = h; clean_flag_i = c; jump_flag_i = j; jump_addr_i = ja; imem_ready_i = r;
  endtask

  // One clock: memory model notes acceptance before the edge and answers MEM_LAT cycles later.
  task automatic step();
    logic acc;
    logic [31:0] aa;
    acc = imem_req_o & imem_ready_i;
    aa = imem_addr_o;
    @(posedge clk);
    #1;
    model_rv = 1'b0;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (acc) begin pend = 1'b1; cnt = MEM_LAT; paddr = aa; end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin pend = 1'b0; model_rv = 1'b1; end
      end
    end
    imem_rvalid_i = model_rv | stray_rv;
    imem_rdata_i = model_rv ? w(paddr) : 32'hDEAD_BEEF;
  endtask

  initial begin
    tbl[0]  = v(0,0,0,32'h0,1, 1,0, B,             N,            32'h0);
    tbl[1]  = v(0,0,0,32'h0,1, 0,1, B,             N,            32'h0);
    tbl[2]  = v(0,0,0,32'h0,1, 0,1, B,             N,            32'h0);
    tbl[3]  = v(0,0,0,32'h0,1, 1,0, B+32'h4,       w(B),         B);
    tbl[4]  = v(0,0,0,32'h0,1, 0,1, B+32'h4,       N,            B);
    tbl[5]  = v(0,0,0,32'h0,1, 0,1, B+32'h4,       N,            B);
    tbl[6]  = v(1,0,0,32'h0,1, 0,1, B+32'h4,       N,            B);
    tbl[7]  = v(1,0,0,32'h0,1, 0,1, B+32'h4,       N,            B);
    tbl[8]  = v(0,0,0,32'h0,1, 1,0, B+32'h8,       32'h93,       B+32'h4);
    tbl[9]  = v(0,0,0,32'h0,1, 0,1, B+32'h8,       N,            B+32'h4);
    tbl[10] = v(0,0,0,32'h0,1, 0,1, B+32'h8,       N,            B+32'h4);
    tbl[11] = v(0,0,0,32'h0,1, 1,0, B+32'hC,       w(B+32'h8),   B+32'h8);
    tbl[12] = v(0,0,0,32'h0,0, 1,0, B+32'hC,       N,            B+32'h8);
    tbl[13] = v(0,0,0,32'h0,1, 0,1, B+32'hC,       N,            B+32'h8);
    tbl[14] = v(0,0,0,32'h0,1, 0,1, B+32'hC,       N,            B+32'h8);
    tbl[15] = v(0,1,0,32'h0,1, 1,0, B+32'h10,      N,            B+32'h8);
    tbl[16] = v(0,0,0,32'h0,1, 0,1, B+32'h10,      N,            B+32'h8);
    tbl[17] = v(0,0,0,32'h0,1, 0,1, B+32'h10,      N,            B+32'h8);
    tbl[18] = v(0,0,0,32'h0,1, 1,0, B+32'h14,      w(B+32'h10),  B+32'h10);
    tbl[19] = v(0,0,0,32'h0,1, 0,1, B+32'h14,      N,            B+32'h10);
    tbl[20] = v(0,0,1,32'h8000_0103,1, 0,1, B+32'h100, N,        B+32'h10);
    tbl[21] = v(0,0,0,32'h0,1, 1,0, B+32'h100,     N,            B+32'h10);
    tbl[22] = v(0,0,0,32'h0,1, 0,1, B+32'h100,     N,            B+32'h10);
    tbl[23] = v(0,0,0,32'h0,1, 0,1, B+32'h100,     N,            B+32'h10);
    tbl[24] = v(0,0,0,32'h0,1, 1,0, B+32'h104,     w(B+32'h100), B+32'h100);

    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 1'b1, 1'b0, B, N, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      set_in(tbl[i].h, tbl[i].c, tbl[i].j, tbl[i].ja, tbl[i].r);
      step();
      chk_out($sformatf("row%0d", i), tbl[i].e_req, tbl[i].e_busy, 1'b0,
              tbl[i].e_addr, tbl[i].e_instr, tbl[i].e_pc);
    end

    // Redirect to the top word, then jump+clean together, then wrap-around fetch.
    set_in(0,0,1,32'hFFFF_FFFF,0); step();
    chk_out("jmp_top", 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, N, B+32'h100);
    set_in(0,1,1,32'h0000_0040,0); step();
    chk_out("jmp_clean", 1'b1, 1'b0, 1'b0, 32'h0000_0040, N, B+32'h100);
    set_in(0,0,1,32'hFFFF_FFFC,0); step();
    set_in(0,0,0,32'h0,1); step(); step(); step();
    chk_out("wrap", 1'b1, 1'b0, 1'b0, 32'h0000_0000, w(32'hFFFF_FFFC), 32'hFFFF_FFFC);

    // Redirect coinciding with accept: the response must be discarded.
    set_in(0,0,1,32'h8000_0200,1); step();
    chk_out("jmp_accept", 1'b0, 1'b1, 1'b0, B+32'h200, N, 32'hFFFF_FFFC);
    set_in(0,0,0,32'h0,0); step(); step();
    chk_out("jmp_accept_drop", 1'b1, 1'b0, 1'b0, B+32'h200, N, 32'hFFFF_FFFC);
    set_in(0,0,0,32'h0,1); step(); step(); step();
    chk_out("after_jmp_accept", 1'b1, 1'b0, 1'b0, B+32'h204, w(B+32'h200), B+32'h200);

    // Redirect while the skid buffer is full.
    step(); step();
    set_in(1,0,0,32'h0,1); step();
    chk_out("enter_buf", 1'b0, 1'b1, 1'b0, B+32'h204, N, B+32'h200);
    set_in(1,0,1,32'h8000_0300,0); step();
    chk_out("jmp_buf", 1'b1, 1'b0, 1'b0, B+32'h300, N, B+32'h200);
    set_in(0,0,0,32'h0,0); step();
    chk_out("buf_emptied", 1'b1, 1'b0, 1'b0, B+32'h300, N, B+32'h200);

    // Reset pulse in WAIT, then stray rvalid in IDLE/REQ.
    set_in(0,0,0,32'h0,1); step();
    #2;
    rst_n = 1'b0;
    pend = 1'b0;
    imem_rvalid_i = 1'b0;
    #1;
    chk_out("rst_async", 1'b0, 1'b1, 1'b0, B, N, 32'h0);
    step();
    rst_n = 1'b1;
    stray_rv = 1'b1;
    imem_rvalid_i = 1'b1;
    set_in(0,0,0,32'h0,0); step();
    chk_out("stray_idle", 1'b1, 1'b0, 1'b0, B, N, 32'h0);
    step();
    chk_out("stray_req", 1'b1, 1'b0, 1'b0, B, N, 32'h0);
    stray_rv = 1'b0;
    imem_rvalid_i = 1'b0;
    set_in(0,0,0,32'h0,1); step(); step(); step();
    chk_out("post_rst_fetch", 1'b1, 1'b0, 1'b0, B+32'h4, w(B), B);

    // Timer interrupt raised in the accept cycle rides on the next loaded word.
    timer_interrupt_i = 1'b1;
    step(); step(); step();
    chk_out("irq_load", 1'b1, 1'b0, EXP_IRQ, B+32'h8, 32'h93, B+32'h4);
    step();
    chk_out("irq_bubble", 1'b0, 1'b1, 1'b0, B+32'h8, N, B+32'h4);
    timer_interrupt_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
